// File: rtl/wd_access_arbiter_if.sv
// Bus bundle between the LPC host, the BMC sideband, the auto-kick pacing inputs
// and the watchdog register port of wd_access_arbiter.
interface wd_access_arbiter_if;
    logic       HostReq;
    logic       HostRead;
    logic [7:0] HostData;
    logic       BmcReq;
    logic       BmcRead;
    logic [7:0] BmcData;
    logic       HostAck;
    logic       BmcAck;
    logic       AckErr;
    logic [7:0] RdData;
    logic       Strobe125msec;
    logic       KickEnable;
    logic [4:0] KickValue;
    logic       WdWrite;
    logic       WdRead;
    logic [4:0] WdAddress;
    logic [7:0] WdData;
    logic [6:0] WatchDogRegister;
    logic       WatchDogReset;

    // Arbiter side: consumes requests and watchdog status, drives acks and strobes.
    modport slave (
        input  HostReq, HostRead, HostData,
        input  BmcReq, BmcRead, BmcData,
        input  Strobe125msec, KickEnable, KickValue,
        input  WatchDogRegister, WatchDogReset,
        output HostAck, BmcAck, AckErr, RdData,
        output WdWrite, WdRead, WdAddress, WdData
    );

    modport master (
        output HostReq, HostRead, HostData,
        output BmcReq, BmcRead, BmcData,
        output Strobe125msec, KickEnable, KickValue,
        output WatchDogRegister, WatchDogReset,
        input  HostAck, BmcAck, AckErr, RdData,
        input  WdWrite, WdRead, WdAddress, WdData
    );
endinterface

// File: rtl/wd_access_arbiter.sv
// Round-robin arbiter serialising host, BMC and (with `define WD_AUTOKICK_EN) a
// periodic auto-kicker onto single-cycle accesses of the watchdog register.
module wd_access_arbiter (
    input  logic               LpcClock,
    input  logic               Reset,
    wd_access_arbiter_if.slave bus
);
    localparam logic [4:0] WD_ADDR   = 5'hB;
    localparam logic [1:0] SLOT_HOST = 2'd0;
    localparam logic [1:0] SLOT_BMC  = 2'd1;
    localparam logic [1:0] SLOT_KICK = 2'd2;
`ifdef WD_AUTOKICK_EN
    localparam int NUM_SLOTS = 3;
`else
    localparam int NUM_SLOTS = 2;
`endif

    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, SETTLE, ACK} stateT;

    stateT      state, stateNext;
    logic [1:0] rrPtr, rrPtrNext;
    logic [1:0] winner, winnerNext;
    logic [2:0] reqVec;
    logic       latRead, latErr;
    logic       grantRead;
    logic [7:0] grantData;
    logic       kickPending;
    logic [7:0] kickData;
    logic       wdWriteNext, wdReadNext;
    logic [4:0] wdAddressNext;
    logic [7:0] wdDataNext, rdDataNext;
    logic       hostAckNext, bmcAckNext, ackErrNext;

    // First requesting slot at or after the pointer; earlier scan positions win.
    function automatic logic [1:0] pickWinner(input logic [2:0] req, input logic [1:0] ptr);
        int slot;
        pickWinner = ptr;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            slot = (int'(ptr) + i) % NUM_SLOTS;
            if (req[2'(slot)]) pickWinner = 2'(slot);
        end
    endfunction

    function automatic logic [1:0] nextSlot(input logic [1:0] slot);
        nextSlot = (int'(slot) >= NUM_SLOTS - 1) ? 2'd0 : slot + 2'd1;
    endfunction

    assign reqVec = {kickPending, bus.BmcReq, bus.HostReq};

    always_comb begin
        grantRead = 1'b0;
        grantData = kickData;
        case (winner)
            SLOT_HOST: begin
                grantRead = bus.HostRead;
                grantData = bus.HostData;
            end
            SLOT_BMC: begin
                grantRead = bus.BmcRead;
                grantData = bus.BmcData;
            end
            default: ;
        endcase
    end

    always_ff @(posedge LpcClock) begin
        if (Reset) begin
            state  <= IDLE;
            rrPtr  <= 2'd0;
            winner <= SLOT_HOST;
        end else begin
            state  <= stateNext;
            rrPtr  <= rrPtrNext;
            winner <= winnerNext;
        end
    end

    always_comb begin
        stateNext     = state;
        rrPtrNext     = rrPtr;
        winnerNext    = winner;
        wdWriteNext   = 1'b0;
        wdReadNext    = 1'b0;
        wdAddressNext = 5'h00;
        wdDataNext    = 8'h00;
        hostAckNext   = 1'b0;
        bmcAckNext    = 1'b0;
        ackErrNext    = 1'b0;
        rdDataNext    = bus.RdData;
        unique case (state)
            IDLE: begin
                if (|reqVec) begin
                    stateNext  = GRANT;
                    winnerNext = pickWinner(reqVec, rrPtr);
                end
            end
            GRANT: begin
                stateNext   = ISSUE;
                rrPtrNext   = nextSlot(winner);
                // A pending watchdog reset blocks writes but never reads.
                wdReadNext  = grantRead;
                wdWriteNext = !grantRead && !bus.WatchDogReset;
                if (wdReadNext || wdWriteNext) begin
                    wdAddressNext = WD_ADDR;
                    wdDataNext    = grantData;
                end
            end
            ISSUE: stateNext = SETTLE;
            SETTLE: begin
                stateNext   = ACK;
                rdDataNext  = latRead ? {1'b0, bus.WatchDogRegister} : 8'h00;
                hostAckNext = (winner == SLOT_HOST);
                bmcAckNext  = (winner == SLOT_BMC);
                ackErrNext  = latErr && (winner != SLOT_KICK);
            end
            ACK: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // GRANT snapshot: the access completes even if the requester drops Req now.
    always_ff @(posedge LpcClock) begin
        if (state == GRANT) begin
            latRead <= grantRead;
            latErr  <= bus.WatchDogReset && !grantRead;
        end
    end

    always_ff @(posedge LpcClock) begin
        if (Reset) begin
            bus.WdWrite   <= 1'b0;
            bus.WdRead    <= 1'b0;
            bus.WdAddress <= 5'h00;
            bus.WdData    <= 8'h00;
            bus.HostAck   <= 1'b0;
            bus.BmcAck    <= 1'b0;
            bus.AckErr    <= 1'b0;
            bus.RdData    <= 8'h00;
        end else begin
            bus.WdWrite   <= wdWriteNext;
            bus.WdRead    <= wdReadNext;
            bus.WdAddress <= wdAddressNext;
            bus.WdData    <= wdDataNext;
            bus.HostAck   <= hostAckNext;
            bus.BmcAck    <= bmcAckNext;
            bus.AckErr    <= ackErrNext;
            bus.RdData    <= rdDataNext;
        end
    end

`ifdef WD_AUTOKICK_EN
    logic [2:0] kickCount;
    logic       kickWrap, kickClear;

    assign kickWrap  = bus.KickEnable && bus.Strobe125msec && (kickCount == 3'd7);
    assign kickClear = (state == ACK) && (winner == SLOT_KICK);

    // A fresh eighth strobe outranks the clear so a back-to-back kick is not lost.
    always_ff @(posedge LpcClock) begin
        if (Reset) begin
            kickCount   <= 3'd0;
            kickPending <= 1'b0;
        end else begin
            if (!bus.KickEnable)
                kickCount <= 3'd0;
            else if (bus.Strobe125msec)
                kickCount <= kickCount + 3'd1;
            if (kickWrap)
                kickPending <= 1'b1;
            else if (kickClear)
                kickPending <= 1'b0;
        end
    end

    always_ff @(posedge LpcClock) begin
        if (kickWrap) kickData <= {3'b000, bus.KickValue};
    end
`else
    logic unusedKick;

    assign kickPending = 1'b0;
    assign kickData    = 8'h00;
    assign unusedKick  = ^{bus.Strobe125msec, bus.KickEnable, bus.KickValue};
`endif

endmodule

// File: tb/tb_wd_access_arbiter.sv
// Directed bench for wd_access_arbiter; kick expectations follow WD_AUTOKICK_EN.
module tb_wd_access_arbiter;
`ifdef WD_AUTOKICK_EN
    localparam int KICK_ON = 1;
`else
    localparam int KICK_ON = 0;
`endif

    logic LpcClock = 1'b0;
    logic Reset;
    wd_access_arbiter_if bus ();

    wd_access_arbiter dut (
        .LpcClock(LpcClock),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #15 LpcClock = ~LpcClock;

    int errCount = 0;
    int checkCount = 0;
    int wrCount = 0, rdCount = 0, bothCount = 0, hostAckCount = 0, bmcAckCount = 0;
    logic [7:0] lastWrData = 8'h00;
    int wr0, rd0, ha0, ba0;
    logic [7:0] lastWr0;
    logic [1:0] who;

    always @(negedge LpcClock) begin
        if (bus.WdWrite === 1'b1) begin
            wrCount++;
            lastWrData = bus.WdData;
        end
        if (bus.WdRead === 1'b1) rdCount++;
        if (bus.WdWrite === 1'b1 && bus.WdRead === 1'b1) bothCount++;
        if (bus.HostAck === 1'b1) hostAckCount++;
        if (bus.BmcAck === 1'b1) bmcAckCount++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (observed running, required done)");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge LpcClock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitAnyAck(input int budget, output logic [1:0] seen);
        seen = 2'b00;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.HostAck === 1'b1 || bus.BmcAck === 1'b1) begin
                seen = {bus.BmcAck, bus.HostAck};
                break;
            end
        end
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Strobe125msec = 1'b1;
            tick();
            bus.Strobe125msec = 1'b0;
            tick();
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus.HostReq = 1'b0; bus.HostRead = 1'b0; bus.HostData = 8'h00;
        bus.BmcReq = 1'b0;  bus.BmcRead = 1'b0;  bus.BmcData = 8'h00;
        bus.Strobe125msec = 1'b0; bus.KickEnable = 1'b0; bus.KickValue = 5'h00;
        bus.WatchDogRegister = 7'h00; bus.WatchDogReset = 1'b0;
        repeat (3) tick();

        chk("rst_hostack", bus.HostAck, 0);
        chk("rst_bmcack", bus.BmcAck, 0);
        chk("rst_ackerr", bus.AckErr, 0);
        chk("rst_wdwrite", bus.WdWrite, 0);
        chk("rst_wdread", bus.WdRead, 0);
        chk("rst_rddata", bus.RdData, 8'h00);
        chk("rst_wddata", bus.WdData, 8'h00);
        chk("rst_wdaddr", bus.WdAddress, 5'h00);
        Reset = 1'b0;
        tick();

        // Host write 0x15, cycle by cycle.
        wr0 = wrCount;
        bus.HostReq = 1'b1; bus.HostRead = 1'b0; bus.HostData = 8'h15;
        tick();
        chk("hw_grant_nowr", bus.WdWrite, 0);
        tick();
        chk("hw_issue_wr", bus.WdWrite, 1);
        chk("hw_issue_rd", bus.WdRead, 0);
        chk("hw_issue_data", bus.WdData, 8'h15);
        chk("hw_issue_addr", bus.WdAddress, 5'h0B);
        chk("hw_issue_noack", bus.HostAck, 0);
        tick();
        chk("hw_settle_wr", bus.WdWrite, 0);
        chk("hw_settle_addr", bus.WdAddress, 5'h00);
        chk("hw_settle_noack", bus.HostAck, 0);
        tick();
        chk("hw_ack", bus.HostAck, 1);
        chk("hw_ackerr", bus.AckErr, 0);
        chk("hw_bmcack", bus.BmcAck, 0);
        chk("hw_rddata", bus.RdData, 8'h00);
        bus.HostReq = 1'b0;
        tick();
        chk("hw_ack_pulse", bus.HostAck, 0);
        chk("hw_one_write", wrCount - wr0, 1);

        // BMC read with WatchDogRegister = 0x5A.
        rd0 = rdCount;
        bus.WatchDogRegister = 7'h5A;
        bus.BmcReq = 1'b1; bus.BmcRead = 1'b1; bus.BmcData = 8'h33;
        tick();
        tick();
        chk("br_issue_rd", bus.WdRead, 1);
        chk("br_issue_wr", bus.WdWrite, 0);
        chk("br_issue_data", bus.WdData, 8'h33);
        chk("br_issue_addr", bus.WdAddress, 5'h0B);
        tick();
        tick();
        chk("br_ack", bus.BmcAck, 1);
        chk("br_rddata", bus.RdData, 8'h5A);
        chk("br_ackerr", bus.AckErr, 0);
        chk("br_hostack", bus.HostAck, 0);
        bus.BmcReq = 1'b0;
        tick();
        chk("br_ack_pulse", bus.BmcAck, 0);
        chk("br_one_read", rdCount - rd0, 1);

        // Simultaneous host and BMC writes straight after reset.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.HostReq = 1'b1; bus.HostRead = 1'b0; bus.HostData = 8'h21;
        bus.BmcReq = 1'b1;  bus.BmcRead = 1'b0;  bus.BmcData = 8'h42;
        tick();
        tick();
        chk("both_first_wr", bus.WdWrite, 1);
        chk("both_first_data", bus.WdData, 8'h21);
        tick();
        tick();
        chk("both_host_ack", bus.HostAck, 1);
        chk("both_host_bmcack", bus.BmcAck, 0);
        bus.HostReq = 1'b0;
        tick();
        chk("both_idle_noack", bus.HostAck, 0);
        tick();
        tick();
        chk("both_second_wr", bus.WdWrite, 1);
        chk("both_second_data", bus.WdData, 8'h42);
        tick();
        tick();
        chk("both_bmc_ack", bus.BmcAck, 1);
        chk("both_bmc_hostack", bus.HostAck, 0);
        bus.BmcReq = 1'b0;
        tick();

        // Pointer moves past the host after it is served alone.
        bus.HostReq = 1'b1; bus.HostData = 8'h01;
        waitAnyAck(12, who);
        chk("rr_host_alone", who, 2'b01);
        bus.HostReq = 1'b0;
        tick();
        bus.HostReq = 1'b1; bus.BmcReq = 1'b1;
        waitAnyAck(12, who);
        chk("rr_bmc_first", who, 2'b10);
        bus.BmcReq = 1'b0;
        waitAnyAck(12, who);
        chk("rr_host_second", who, 2'b01);
        bus.HostReq = 1'b0;
        tick();

        // WatchDogReset: reads proceed, writes are refused with AckErr.
        bus.WatchDogReset = 1'b1;
        bus.WatchDogRegister = 7'h7F;
        bus.BmcReq = 1'b1; bus.BmcRead = 1'b1; bus.BmcData = 8'h00;
        tick();
        tick();
        chk("wdr_read_strobe", bus.WdRead, 1);
        tick();
        tick();
        chk("wdr_read_ack", bus.BmcAck, 1);
        chk("wdr_read_ackerr", bus.AckErr, 0);
        chk("wdr_read_data", bus.RdData, 8'h7F);
        bus.BmcReq = 1'b0;
        tick();
        wr0 = wrCount;
        bus.HostReq = 1'b1; bus.HostRead = 1'b0; bus.HostData = 8'h07;
        tick();
        tick();
        chk("wdr_write_nowr", bus.WdWrite, 0);
        chk("wdr_write_nord", bus.WdRead, 0);
        tick();
        tick();
        chk("wdr_write_ack", bus.HostAck, 1);
        chk("wdr_write_ackerr", bus.AckErr, 1);
        chk("wdr_write_rddata", bus.RdData, 8'h00);
        bus.HostReq = 1'b0;
        tick();
        chk("wdr_ackerr_pulse", bus.AckErr, 0);
        chk("wdr_no_writes", wrCount - wr0, 0);
        bus.WatchDogReset = 1'b0;

        // Reset while the write strobe is out aborts the access.
        ha0 = hostAckCount;
        bus.HostReq = 1'b1; bus.HostRead = 1'b0; bus.HostData = 8'h55;
        tick();
        tick();
        chk("abort_issue_wr", bus.WdWrite, 1);
        Reset = 1'b1;
        tick();
        chk("abort_wr_cleared", bus.WdWrite, 0);
        chk("abort_wddata", bus.WdData, 8'h00);
        Reset = 1'b0;
        bus.HostReq = 1'b0;
        bus.BmcReq = 1'b1; bus.BmcRead = 1'b0; bus.BmcData = 8'h66;
        tick();
        tick();
        chk("abort_new_wr", bus.WdWrite, 1);
        chk("abort_new_data", bus.WdData, 8'h66);
        tick();
        tick();
        chk("abort_new_ack", bus.BmcAck, 1);
        bus.BmcReq = 1'b0;
        tick();
        chk("abort_no_hostack", hostAckCount - ha0, 0);

        // Auto-kick: the eighth enabled strobe triggers a write of {3'b0, KickValue}.
        bus.KickEnable = 1'b1; bus.KickValue = 5'h1F;
        ha0 = hostAckCount; ba0 = bmcAckCount;
        wr0 = wrCount; lastWr0 = lastWrData;
        tick();
        strobes(7);
        repeat (3) tick();
        chk("kick_7_nowr", wrCount - wr0, 0);
        strobes(1);
        repeat (8) tick();
        chk("kick_8_wr", wrCount - wr0, KICK_ON);
        chk("kick_8_data", lastWrData, (KICK_ON != 0) ? 8'h1F : lastWr0);
        chk("kick_no_acks", (hostAckCount - ha0) + (bmcAckCount - ba0), 0);

        // Dropping KickEnable restarts the strobe count.
        wr0 = wrCount; lastWr0 = lastWrData;
        strobes(4);
        bus.KickEnable = 1'b0;
        tick();
        bus.KickEnable = 1'b1; bus.KickValue = 5'h0A;
        strobes(4);
        repeat (8) tick();
        chk("kick_cleared_nowr", wrCount - wr0, 0);
        strobes(4);
        repeat (8) tick();
        chk("kick_restart_wr", wrCount - wr0, KICK_ON);
        chk("kick_restart_data", lastWrData, (KICK_ON != 0) ? 8'h0A : lastWr0);
        bus.KickEnable = 1'b0;
        tick();

        chk("never_both_strobes", bothCount, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
